// File: rtl/std_cache_pkg.sv
// Shared types and helpers for the banked data-cache arbitration stage.
//   dcache_entry_t : one way entry {tag, valid, dirty, data}
//   dcache_be_t    : byte enables plus valid/dirty enables, same field order
//   bank_idx()     : bank selected by a byte index (interleaved on line index)
package std_cache_pkg;

  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned DCACHE_TAG_WIDTH  = 44;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic                         valid;
    logic                         dirty;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } dcache_entry_t;

  typedef struct packed {
    logic                           valid;
    logic                           dirty;
    logic [DCACHE_LINE_WIDTH/8-1:0] data;
  } dcache_be_t;

  // Banks interleave on the lowest line-index bits; one bank maps to 0.
  function automatic int unsigned bank_idx(input logic [31:0]  addr,
                                           input int unsigned byte_off,
                                           input int unsigned bank_bits);
    if (bank_bits == 0) return 0;
    return (addr >> byte_off) & ((32'd1 << bank_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/std_dcache_rr_arb.sv
// Per-bank arbiter: port 0 has absolute priority, ports 1..NumPorts-1 share
// the bank round-robin. While lock_hold_i is set only port 0 may win.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : ports requesting this bank
//   lock_hold_i   : bank is held by port 0 this cycle
//   gnt_o         : one-hot grant
//   win_o, vld_o  : winning port index, bank in use
module std_dcache_rr_arb #(
  parameter  int unsigned NumPorts = 5,
  localparam int unsigned PortW    = $clog2(NumPorts)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] req_i,
  input  logic                lock_hold_i,
  output logic [NumPorts-1:0] gnt_o,
  output logic [PortW-1:0]    win_o,
  output logic                vld_o
);

  logic [PortW-1:0] rr_q, rr_d;
  int unsigned      cand;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    vld_o = 1'b0;
    rr_d  = rr_q;
    cand  = 0;
    if (req_i[0]) begin
      gnt_o[0] = 1'b1;
      vld_o    = 1'b1;
    end else if (!lock_hold_i) begin
      // Scan core ports starting at rr_q, wrapping NumPorts-1 -> 1.
      for (int unsigned k = 0; k < NumPorts - 1; k++) begin
        if (!vld_o) begin
          cand = (32'(rr_q) + k - 1) % (NumPorts - 1) + 1;
          if (req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            win_o       = PortW'(cand);
            vld_o       = 1'b1;
            rr_d        = (cand == NumPorts - 1) ? PortW'(1) : PortW'(cand + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= PortW'(1);
    else         rr_q <= rr_d;
  end

endmodule

// File: rtl/std_dcache_bank_arb.sv
// Banked data-cache arbitration and late tag compare.
// NumPorts requesters (port 0 = miss handler) share NumBanks SRAM banks;
// each bank grants one requester per cycle. Read data returns one cycle
// after the grant and is compared per way against tag_i of the reader.
//   req_i/lock_i/addr_i/we_i/be_i/wdata_i/tag_i : requester side
//   gnt_o, rvalid_o, rdata_o, hit_way_o          : requester responses
//   bank_*_o / bank_rdata_i                      : SRAM bank side
module std_dcache_bank_arb
  import std_cache_pkg::*;
#(
  parameter  int unsigned NumPorts   = 5,
  parameter  int unsigned NumBanks   = 2,
  parameter  int unsigned SetAssoc   = 8,
  parameter  int unsigned IndexWidth = 12,
  parameter  int unsigned ByteOffset = 4,
  parameter  int unsigned TagWidth   = 44,
  parameter  int unsigned LineWidth  = 128,
  localparam int unsigned BankBits   = (NumBanks > 1) ? $clog2(NumBanks) : 0,
  localparam int unsigned BankIdxW   = (NumBanks > 1) ? BankBits : 1,
  localparam int unsigned BankAddrW  = IndexWidth - ByteOffset - BankBits,
  localparam int unsigned EntryW     = TagWidth + 2 + LineWidth,
  localparam int unsigned BeW        = LineWidth / 8 + 2,
  localparam int unsigned PortW      = $clog2(NumPorts)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NumPorts-1:0][SetAssoc-1:0]             req_i,
  input  logic                                          lock_i,
  input  logic [NumPorts-1:0][IndexWidth-1:0]           addr_i,
  input  logic [NumPorts-1:0]                           we_i,
  input  logic [NumPorts-1:0][BeW-1:0]                  be_i,
  input  logic [NumPorts-1:0][EntryW-1:0]               wdata_i,
  input  logic [NumPorts-1:0][TagWidth-1:0]             tag_i,
  output logic [NumPorts-1:0]                           gnt_o,
  output logic [NumPorts-1:0]                           rvalid_o,
  output logic [SetAssoc-1:0][EntryW-1:0]               rdata_o,
  output logic [NumPorts-1:0][SetAssoc-1:0]             hit_way_o,
  output logic [NumBanks-1:0][SetAssoc-1:0]             bank_req_o,
  output logic [NumBanks-1:0]                           bank_we_o,
  output logic [NumBanks-1:0][BankAddrW-1:0]            bank_addr_o,
  output logic [NumBanks-1:0][BeW-1:0]                  bank_be_o,
  output logic [NumBanks-1:0][EntryW-1:0]               bank_wdata_o,
  input  logic [NumBanks-1:0][SetAssoc-1:0][EntryW-1:0] bank_rdata_i
);

  logic [NumPorts-1:0][BankIdxW-1:0] bsel;
  logic [NumBanks-1:0][NumPorts-1:0] breq, bgnt;
  logic [NumBanks-1:0][PortW-1:0]    win;
  logic [NumBanks-1:0]               bvld, lock_hold;

  logic                              lock_q, lock_d;
  logic [BankIdxW-1:0]               lock_bank_q, lock_bank_d;
  logic [NumBanks-1:0]               resp_valid_q, resp_valid_d;
  logic [NumBanks-1:0][PortW-1:0]    resp_port_q, resp_port_d;

  always_comb begin
    for (int unsigned p = 0; p < NumPorts; p++)
      bsel[p] = BankIdxW'(bank_idx(32'(addr_i[p]), ByteOffset, BankBits));
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    for (genvar p = 0; p < NumPorts; p++) begin : g_port
      assign breq[b][p] = (|req_i[p]) && (bsel[p] == BankIdxW'(b));
    end

    // Lock only holds while lock_i stays high; its fall releases the bank
    // in the same cycle.
    assign lock_hold[b] = lock_q && lock_i && (lock_bank_q == BankIdxW'(b));

    std_dcache_rr_arb #(.NumPorts(NumPorts)) i_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (breq[b]),
      .lock_hold_i (lock_hold[b]),
      .gnt_o       (bgnt[b]),
      .win_o       (win[b]),
      .vld_o       (bvld[b])
    );

    assign bank_req_o[b]   = bvld[b] ? req_i[win[b]] : '0;
    assign bank_we_o[b]    = bvld[b] & we_i[win[b]];
    assign bank_addr_o[b]  = bvld[b] ? addr_i[win[b]][IndexWidth-1 -: BankAddrW] : '0;
    assign bank_be_o[b]    = bvld[b] ? be_i[win[b]] : '0;
    assign bank_wdata_o[b] = bvld[b] ? wdata_i[win[b]] : '0;

    assign resp_valid_d[b] = bvld[b] & ~we_i[win[b]];
    assign resp_port_d[b]  = win[b];
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned b = 0; b < NumBanks; b++) gnt_o |= bgnt[b];
  end

  always_comb begin
    lock_d      = lock_q;
    lock_bank_d = lock_bank_q;
    if (gnt_o[0] && lock_i) begin
      lock_d      = 1'b1;
      lock_bank_d = bsel[0];
    end else if (!lock_i) begin
      lock_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_bank_q  <= '0;
      resp_valid_q <= '0;
      resp_port_q  <= '0;
    end else begin
      lock_q       <= lock_d;
      lock_bank_q  <= lock_bank_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
    end
  end

  // Descending scan so the lowest responding bank owns rdata_o; hits use
  // each responder's own bank so concurrent responders stay correct.
  always_comb begin
    rvalid_o  = '0;
    rdata_o   = '0;
    hit_way_o = '0;
    for (int b = NumBanks - 1; b >= 0; b--) begin
      if (resp_valid_q[b]) begin
        rvalid_o[resp_port_q[b]] = 1'b1;
        rdata_o                  = bank_rdata_i[b];
        for (int unsigned w = 0; w < SetAssoc; w++)
          hit_way_o[resp_port_q[b]][w] = bank_rdata_i[b][w][LineWidth+1] &&
            (bank_rdata_i[b][w][EntryW-1 -: TagWidth] == tag_i[resp_port_q[b]]);
      end
    end
  end

  // A port may have only one read response in flight at a time.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int unsigned b1 = 0; b1 < NumBanks; b1++)
        for (int unsigned b2 = b1 + 1; b2 < NumBanks; b2++)
          assert (!(resp_valid_q[b1] && resp_valid_q[b2] &&
                    resp_port_q[b1] == resp_port_q[b2]));
    end
  end

endmodule

// File: tb/tb_std_dcache_bank_arb.sv
module tb_std_dcache_bank_arb;
  import std_cache_pkg::*;

  localparam int NP = 5, NB = 2, SA = 8, IW = 12, BO = 4, TW = 44, LW = 128;
  localparam int EW = TW + 2 + LW, BEW = LW / 8 + 2, BAW = IW - BO - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NP-1:0][SA-1:0]         req;
  logic                          lock;
  logic [NP-1:0][IW-1:0]         addr;
  logic [NP-1:0]                 we;
  logic [NP-1:0][BEW-1:0]        be;
  logic [NP-1:0][EW-1:0]         wdata;
  logic [NP-1:0][TW-1:0]         tag;
  logic [NP-1:0]                 gnt, rvalid;
  logic [SA-1:0][EW-1:0]         rdata;
  logic [NP-1:0][SA-1:0]         hit;
  logic [NB-1:0][SA-1:0]         breq;
  logic [NB-1:0]                 bwe;
  logic [NB-1:0][BAW-1:0]        baddr;
  logic [NB-1:0][BEW-1:0]        bbe;
  logic [NB-1:0][EW-1:0]         bwdata;
  logic [NB-1:0][SA-1:0][EW-1:0] brdata;

  int tests = 0, fails = 0;

  // reference model state
  int m_rr[NB], m_win[NB], m_rp[NB];
  bit m_rv[NB];
  bit m_lock;
  int m_lock_bank;

  always #5 clk = ~clk;

  std_dcache_bank_arb #(
    .NumPorts(NP), .NumBanks(NB), .SetAssoc(SA), .IndexWidth(IW),
    .ByteOffset(BO), .TagWidth(TW), .LineWidth(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .tag_i(tag), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata), .hit_way_o(hit), .bank_req_o(breq),
    .bank_we_o(bwe), .bank_addr_o(baddr), .bank_be_o(bbe),
    .bank_wdata_o(bwdata), .bank_rdata_i(brdata)
  );

  function automatic int tb_bank(input logic [IW-1:0] a);
    return (int'(a) / (1 << BO)) % NB;
  endfunction

  function automatic logic [EW-1:0] rnd_entry();
    return EW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin m_rr[b] = 1; m_rv[b] = 0; m_rp[b] = 0; end
    m_lock = 0; m_lock_bank = 0;
  endtask

  // Who owns each bank this cycle, straight from the priority rules.
  task automatic model_arb();
    for (int b = 0; b < NB; b++) begin
      m_win[b] = -1;
      if (req[0] != 0 && tb_bank(addr[0]) == b) m_win[b] = 0;
      else if (!(m_lock && lock && m_lock_bank == b)) begin
        for (int p = m_rr[b]; p < NP && m_win[b] < 0; p++)
          if (req[p] != 0 && tb_bank(addr[p]) == b) m_win[b] = p;
        for (int p = 1; p < m_rr[b] && m_win[b] < 0; p++)
          if (req[p] != 0 && tb_bank(addr[p]) == b) m_win[b] = p;
      end
    end
  endtask

  task automatic model_clock();
    int b0 = tb_bank(addr[0]);
    for (int b = 0; b < NB; b++) begin
      m_rv[b] = (m_win[b] >= 0) ? !we[m_win[b]] : 1'b0;
      m_rp[b] = m_win[b];
      if (m_win[b] > 0) m_rr[b] = (m_win[b] == NP - 1) ? 1 : m_win[b] + 1;
    end
    if (m_win[b0] == 0 && lock) begin m_lock = 1; m_lock_bank = b0; end
    else if (!lock) m_lock = 0;
  endtask

  task automatic clear_inputs();
    req = '0; lock = 1'b0; addr = '0; we = '0; be = '0; wdata = '0; tag = '0; brdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #3;
    tests++; if (rvalid !== '0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    tests++; if (hit !== '0) begin fails++; $display("FAIL reset_hit: got %h want 0", hit); end
    tests++; if (gnt !== '0 || breq !== '0 || bwe !== '0) begin
      fails++; $display("FAIL reset_idle: gnt %b breq %h bwe %b want all 0", gnt, breq, bwe); end
    // rr starts at port 1
    for (int p = 1; p < NP; p++) req[p] = 8'hFF;
    #1;
    tests++; if (gnt !== 5'b00010) begin fails++; $display("FAIL reset_rr: got %b want 00010", gnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_parallel_banks();
    logic [SA-1:0][EW-1:0] exp0;
    apply_reset();
    req[1] = 8'hFF; addr[1] = 12'h010;
    req[2] = 8'hFF; addr[2] = 12'h020;
    #3;
    tests++; if (gnt !== 5'b00110) begin fails++; $display("FAIL par_gnt: got %b want 00110", gnt); end
    tests++; if (baddr[0] !== 7'd1 || baddr[1] !== 7'd0) begin
      fails++; $display("FAIL par_addr: got %h/%h want 1/0", baddr[0], baddr[1]); end
    @(posedge clk); #1;
    req = '0;
    for (int b = 0; b < NB; b++) for (int w = 0; w < SA; w++) brdata[b][w] = rnd_entry();
    exp0 = brdata[0];
    #3;
    tests++; if (rvalid !== 5'b00110) begin fails++; $display("FAIL par_rvalid: got %b want 00110", rvalid); end
    tests++; if (rdata !== exp0) begin fails++; $display("FAIL par_rdata: got %h want %h", rdata, exp0); end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_rotation();
    logic [NP-1:0] exp_seq [5];
    exp_seq = '{5'b00010, 5'b00100, 5'b00001, 5'b01000, 5'b00010};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      for (int p = 1; p <= 3; p++) req[p] = 8'hFF;
      req[0] = (c == 2) ? 8'hFF : 8'h00;
      #3;
      tests++; if (gnt !== exp_seq[c]) begin
        fails++; $display("FAIL rr_cyc%0d: got %b want %b", c, gnt, exp_seq[c]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    logic [NP-1:0] exp_seq [5];
    exp_seq = '{5'b00101, 5'b00101, 5'b00100, 5'b00100, 5'b00110};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      lock   = (c < 4);
      req[0] = (c < 2) ? 8'hFF : 8'h00;
      req[1] = 8'hFF;
      req[2] = 8'h01; addr[2] = 12'h010;
      #3;
      tests++; if (gnt !== exp_seq[c]) begin
        fails++; $display("FAIL lock_cyc%0d: got %b want %b", c, gnt, exp_seq[c]); end
      if (c == 2 || c == 3) begin
        tests++; if (breq[0] !== '0) begin
          fails++; $display("FAIL lock_idle_bank%0d: got %h want 0", c, breq[0]); end
      end
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_hit();
    dcache_entry_t e;
    logic [NP-1:0][SA-1:0] exp_hit;
    apply_reset();
    req[3] = 8'hFF; addr[3] = 12'h000;
    @(posedge clk); #1;
    e = '0; e.tag = 44'hABC; e.valid = 1'b1; e.data = {4{$urandom()}};
    brdata[0][3] = e;
    e.valid = 1'b0;
    brdata[0][5] = e;
    tag[3] = 44'hABC;
    exp_hit = '0; exp_hit[3] = 8'b0000_1000;
    #3;
    tests++; if (hit !== exp_hit) begin fails++; $display("FAIL hit_match: got %h want %h", hit, exp_hit); end
    @(posedge clk); #1;
    tag[3] = 44'hABD;
    req = '0;
    #3;
    tests++; if (rvalid !== 5'b01000 || hit !== '0) begin
      fails++; $display("FAIL hit_miss: rvalid %b hit %h want 01000 / 0", rvalid, hit); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_write();
    logic [BEW-1:0] exp_be;
    logic [EW-1:0]  exp_wd;
    apply_reset();
    exp_be = BEW'($urandom());
    exp_wd = rnd_entry();
    req[4] = 8'h0F; we[4] = 1'b1; addr[4] = 12'h130; be[4] = exp_be; wdata[4] = exp_wd;
    #3;
    tests++; if (gnt !== 5'b10000 || bwe !== 2'b10) begin
      fails++; $display("FAIL wr_gnt: gnt %b bwe %b want 10000 / 10", gnt, bwe); end
    tests++; if (bbe[1] !== exp_be || bwdata[1] !== exp_wd || baddr[1] !== 7'd9 || breq[1] !== 8'h0F) begin
      fails++; $display("FAIL wr_bank: be %h addr %h req %h want %h 9 0f", bbe[1], baddr[1], breq[1], exp_be); end
    @(posedge clk); #1;
    clear_inputs();
    #3;
    tests++; if (rvalid !== '0) begin fails++; $display("FAIL wr_rvalid: got %b want 0", rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req[0] = 8'hFF; lock = 1'b1;
    req[2] = 8'hFF; addr[2] = 12'h010;
    #3;
    tests++; if (gnt !== 5'b00101) begin fails++; $display("FAIL rmid_setup: got %b want 00101", gnt); end
    @(posedge clk); #1;
    req = '0;
    rst_n = 1'b0;
    #1;
    tests++; if (rvalid !== '0) begin fails++; $display("FAIL rmid_rvalid: got %b want 0", rvalid); end
    req[1] = 8'hFF; req[3] = 8'hFF;
    #1;
    tests++; if (gnt !== 5'b00010) begin fails++; $display("FAIL rmid_unlock: got %b want 00010", gnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3;
    tests++; if (gnt !== 5'b00010 || rvalid !== '0) begin
      fails++; $display("FAIL rmid_after: gnt %b rvalid %b want 00010 / 0", gnt, rvalid); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NP-1:0]         exp_g, exp_rv;
    logic [SA-1:0][EW-1:0] exp_rd;
    logic [NP-1:0][SA-1:0] exp_hit;
    logic [SA+1+BAW+BEW+EW-1:0] exp_bank, got_bank;
    dcache_entry_t ent;
    int p;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      for (int q = 0; q < NP; q++) begin
        req[q]   = ($urandom_range(0, 2) == 0) ? 8'h00 : SA'($urandom());
        addr[q]  = IW'($urandom());
        we[q]    = ($urandom_range(0, 3) == 0);
        be[q]    = BEW'($urandom());
        wdata[q] = rnd_entry();
        tag[q]   = TW'({$urandom(), $urandom()});
      end
      lock = m_lock ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      for (int b = 0; b < NB; b++) for (int w = 0; w < SA; w++) brdata[b][w] = rnd_entry();
      for (int b = 0; b < NB; b++)
        if (m_rv[b] && $urandom_range(0, 1) == 1) begin
          ent = brdata[b][$urandom_range(0, SA - 1)];
          tag[m_rp[b]] = ent.tag;
        end
      model_arb();
      #3;
      exp_g = '0;
      for (int b = 0; b < NB; b++) if (m_win[b] >= 0) exp_g[m_win[b]] = 1'b1;
      tests++; if (gnt !== exp_g) begin
        fails++; $display("FAIL rnd_gnt cyc%0d: got %b want %b", c, gnt, exp_g); end
      for (int b = 0; b < NB; b++) begin
        p = m_win[b];
        exp_bank = (p < 0) ? '0 :
          {req[p], we[p], BAW'(int'(addr[p]) / (2 * (1 << BO))), be[p], wdata[p]};
        got_bank = {breq[b], bwe[b], baddr[b], bbe[b], bwdata[b]};
        tests++; if (got_bank !== exp_bank) begin
          fails++; $display("FAIL rnd_bank%0d cyc%0d: got req %h we %b addr %h want winner %0d", b, c, breq[b], bwe[b], baddr[b], p); end
      end
      exp_rv = '0; exp_rd = '0; exp_hit = '0;
      for (int b = NB - 1; b >= 0; b--)
        if (m_rv[b]) begin
          exp_rv[m_rp[b]] = 1'b1;
          exp_rd = brdata[b];
          for (int w = 0; w < SA; w++) begin
            ent = brdata[b][w];
            exp_hit[m_rp[b]][w] = ent.valid && (ent.tag == tag[m_rp[b]]);
          end
        end
      tests++; if (rvalid !== exp_rv) begin
        fails++; $display("FAIL rnd_rvalid cyc%0d: got %b want %b", c, rvalid, exp_rv); end
      tests++; if (rdata !== exp_rd) begin
        fails++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", c, rdata, exp_rd); end
      tests++; if (hit !== exp_hit) begin
        fails++; $display("FAIL rnd_hit cyc%0d: got %h want %h", c, hit, exp_hit); end
      @(posedge clk);
      model_clock();
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_parallel_banks();
    test_rr_rotation();
    test_lock();
    test_hit();
    test_write();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
